sobel_stream: RTL

//  Raster-stream Sobel edge detector; successor to the fixed 8-bit 3x3-window core.

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_window.sv | 103 ++++++++++
 rtl/sobel_stream.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Shared constants and helpers for the streaming Sobel detector.
//               C_LATENCY        - cycles from accepted input to output valid
//               C_THRESH_DEFAULT - default reset value of the latched threshold
//               C_STAGE_VALID_W  - width of the per-stage valid vector
//               mag_w()          - magnitude/gradient width for a pixel width
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int C_LATENCY        = 4;
    localparam int C_THRESH_DEFAULT = 240;
    localparam int C_STAGE_VALID_W  = C_LATENCY;

    // Three extra bits hold the signed gradient (|G| <= 4*max) and the
    // unsigned magnitude (|Gx|+|Gy| <= 8*max) without overflow.
    function automatic int mag_w(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_window.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window
// Description : Stage S0 of the Sobel pipeline. Tracks raster column/row,
//               keeps two line buffers and assembles the 3x3 window whose
//               centre is the pixel one row up and one column left of the
//               accepted input. Flags windows that would reach outside the
//               frame (row < 2 or col < 2).
// Ports       : clock, reset_n        - clock, async active-low reset
//               in_valid/in_sof/in_pixel - raster input stream
//               win_valid/win_sof     - stage valid and start-of-frame
//               win_border            - window not fully inside the frame
//               win                   - z0..z8, row-major, z0 = top-left
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window #(
    parameter int PIX_W    = 8,
    parameter int LINE_LEN = 640
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [PIX_W-1:0]      in_pixel,
    output logic                  win_valid,
    output logic                  win_sof,
    output logic                  win_border,
    output logic [8:0][PIX_W-1:0] win
);

    localparam int                 C_COL_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(LINE_LEN - 1);

    logic [C_COL_W-1:0] r_col;
    logic [C_COL_W-1:0] w_col;
    logic [C_COL_W-1:0] w_col_next;
    logic [1:0]         r_row;
    logic [1:0]         w_row;
    logic [1:0]         w_row_next;

    logic [PIX_W-1:0]   r_lb0 [LINE_LEN];
    logic [PIX_W-1:0]   r_lb1 [LINE_LEN];
    logic [PIX_W-1:0]   w_lb0_rd;
    logic [PIX_W-1:0]   w_lb1_rd;

    // A start-of-frame pixel is always position (0,0), whatever the counters say.
    always_comb begin
        w_col      = in_sof ? '0 : r_col;
        w_row      = in_sof ? '0 : r_row;
        w_col_next = w_col + 1'b1;
        w_row_next = w_row;
        if (w_col == C_COL_LAST) begin
            w_col_next = '0;
            // Row only needs to distinguish 0, 1 and "2 or more".
            if (w_row != 2'd2) begin
                w_row_next = w_row + 1'b1;
            end
        end
    end

    // Asynchronous reads return the contents before this cycle's write.
    assign w_lb0_rd = r_lb0[w_col];
    assign w_lb1_rd = r_lb1[w_col];

    // Line buffers carry no reset; stale data only ever lands in border windows.
    always_ff @(posedge clock) begin
        if (in_valid) begin
            r_lb0[w_col] <= in_pixel;
            r_lb1[w_col] <= w_lb0_rd;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_col      <= '0;
            r_row      <= '0;
            win_valid  <= 1'b0;
            win_sof    <= 1'b0;
            win_border <= 1'b1;
            win        <= '0;
        end else begin
            win_valid <= in_valid;
            win_sof   <= in_valid & in_sof;
            if (in_valid) begin
                r_col      <= w_col_next;
                r_row      <= w_row_next;
                win_border <= (w_row < 2'd2) || (w_col < C_COL_W'(2));
                // Shift left; the new right-hand column is {two rows up, one row up, now}.
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= w_lb1_rd;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= w_lb0_rd;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= in_pixel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_stream.sv
`default_nettype none
// ============================================================================
// Module      : sobel_stream
// Description : Raster-stream Sobel edge detector. S0 (sobel_window) builds
//               the 3x3 window; S1 computes Gx/Gy, S2 takes absolute values
//               (zeroed on border windows), S3 sums them and thresholds.
//               Output valid follows the accepted input by exactly 4 cycles.
// Ports       : clock, reset_n        - clock, async active-low reset
//               in_valid/in_sof/in_pixel - raster input, no backpressure
//               threshold             - edge when magnitude > threshold
//               invert                - swap edge/non-edge pixel polarity
//               out_valid/out_sof     - delayed input qualifiers
//               out_pixel             - 0 on edge, all-ones otherwise (invert=0)
//               out_mag               - |Gx| + |Gy|
// Options     : SOBEL_THRESH_REG_EN - threshold latched at each accepted
//               start-of-frame (reset to THRESH_DEFAULT); otherwise the
//               threshold port is used live at S3.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int PIX_W          = 8,
    parameter int LINE_LEN       = 640,
    parameter int THRESH_DEFAULT = C_THRESH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic [PIX_W+2:0] threshold,
    input  logic             invert,
    output logic             out_valid,
    output logic             out_sof,
    output logic [PIX_W-1:0] out_pixel,
    output logic [PIX_W+2:0] out_mag
);

    localparam int C_MAG_W = mag_w(PIX_W);
    localparam int C_PAD   = C_MAG_W - PIX_W;

    if ((THRESH_DEFAULT < 0) || (THRESH_DEFAULT >= (1 << C_MAG_W))) begin : g_thresh_default_check
        $error("THRESH_DEFAULT does not fit in the magnitude width");
    end

    function automatic logic signed [C_MAG_W-1:0] px(input logic [PIX_W-1:0] p);
        return signed'({{C_PAD{1'b0}}, p});
    endfunction

    function automatic logic [C_MAG_W-1:0] abs_mag(input logic signed [C_MAG_W-1:0] g);
        return g[C_MAG_W-1] ? unsigned'(-g) : unsigned'(g);
    endfunction

    logic                      s0_valid;
    logic                      s0_sof;
    logic                      s0_border;
    logic [8:0][PIX_W-1:0]     s0_win;

    // Index n holds the valid/sof of stage Sn.
    logic [C_STAGE_VALID_W-1:1] r_vld;
    logic [C_STAGE_VALID_W-1:1] r_sof;
    logic                       r_border;
    logic signed [C_MAG_W-1:0]  w_gx;
    logic signed [C_MAG_W-1:0]  w_gy;
    logic signed [C_MAG_W-1:0]  r_gx;
    logic signed [C_MAG_W-1:0]  r_gy;
    logic [C_MAG_W-1:0]         r_agx;
    logic [C_MAG_W-1:0]         r_agy;
    logic [C_MAG_W-1:0]         w_mag;
    logic [C_MAG_W-1:0]         w_thr;
    logic                       w_edge;
    logic [PIX_W-1:0]           r_pixel;
    logic [C_MAG_W-1:0]         r_mag;

    sobel_window #(
        .PIX_W    (PIX_W),
        .LINE_LEN (LINE_LEN)
    ) u_window (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .win_valid  (s0_valid),
        .win_sof    (s0_sof),
        .win_border (s0_border),
        .win        (s0_win)
    );

    assign w_gx = (px(s0_win[2]) + (px(s0_win[5]) <<< 1) + px(s0_win[8]))
                - (px(s0_win[0]) + (px(s0_win[3]) <<< 1) + px(s0_win[6]));
    assign w_gy = (px(s0_win[0]) + (px(s0_win[1]) <<< 1) + px(s0_win[2]))
                - (px(s0_win[6]) + (px(s0_win[7]) <<< 1) + px(s0_win[8]));

`ifdef SOBEL_THRESH_REG_EN
    logic [C_MAG_W-1:0] r_thr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_thr <= C_MAG_W'(THRESH_DEFAULT);
        end else if (in_valid && in_sof) begin
            r_thr <= threshold;
        end
    end

    assign w_thr = r_thr;
`else
    assign w_thr = threshold;
`endif

    assign w_mag  = r_agx + r_agy;
    assign w_edge = (w_mag > w_thr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld    <= '0;
            r_sof    <= '0;
            r_border <= 1'b1;
            r_gx     <= '0;
            r_gy     <= '0;
            r_agx    <= '0;
            r_agy    <= '0;
            r_pixel  <= '1;
            r_mag    <= '0;
        end else begin
            r_vld <= {r_vld[C_STAGE_VALID_W-2:1], s0_valid};
            r_sof <= {r_sof[C_STAGE_VALID_W-2:1], s0_sof};
            if (s0_valid) begin
                r_gx     <= w_gx;
                r_gy     <= w_gy;
                r_border <= s0_border;
            end
            if (r_vld[1]) begin
                r_agx <= r_border ? '0 : abs_mag(r_gx);
                r_agy <= r_border ? '0 : abs_mag(r_gy);
            end
            // Output data holds its last value across bubbles.
            if (r_vld[2]) begin
                r_mag   <= w_mag;
                r_pixel <= (w_edge ^ invert) ? '0 : '1;
            end
        end
    end

    assign out_valid = r_vld[C_STAGE_VALID_W-1];
    assign out_sof   = r_sof[C_STAGE_VALID_W-1];
    assign out_pixel = r_pixel;
    assign out_mag   = r_mag;

endmodule
`default_nettype wire
